// File: rtl/ifetch_pkg.sv
// Shared types and sizing for the prefetching fetch stage.
// Optional perf counters are enabled with IFETCH_PERF_EN.
package ifetch_pkg;

   localparam int IF_XLEN      = 32;
   localparam int IF_AW        = 32;
   localparam int IF_DEPTH     = 4;
   localparam int IF_MAX_OUTST = 2;

   localparam int CNT_W   = $clog2(IF_DEPTH) + 1;
   localparam int OUTST_W = $clog2(IF_MAX_OUTST) + 1;

   typedef struct packed {
      logic [IF_XLEN-1:0] instr;
      logic [IF_AW-1:0]   npc;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with flush, used for fetch entries and tags.
// Push is accepted when full only if a pop happens in the same cycle.
module ifetch_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           dout,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic          full;
   logic          empty;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Empty FIFO presents zero so the head is clean after reset/flush.
   assign dout = empty ? '0 : mem[rptr];

   // Pointer and occupancy tracking; flush empties in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push)
            wptr <= wptr + 1'b1;
         if (do_pop)
            rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array, no reset needed since dout is masked when empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wptr] <= din;
   end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch stage with a credit-limited prefetch queue.
// IFETCH_PERF_EN adds perf_fetch/perf_flush/perf_stall counters.
module ifetch_prefetch
   import ifetch_pkg::*;
#(
   parameter int             XLEN      = IF_XLEN,
   parameter int             AW        = IF_AW,
   parameter int             DEPTH     = IF_DEPTH,
   parameter int             MAX_OUTST = IF_MAX_OUTST,
   parameter logic [AW-1:0]  RESET_PC  = '0,
   parameter int             PC_INC    = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ex_mem_pcsrc,
   input  logic [AW-1:0]             ex_mem_npc,
   output logic                      imem_req,
   output logic [AW-1:0]             imem_addr,
   input  logic                      imem_gnt,
   input  logic                      imem_rvalid,
   input  logic [XLEN-1:0]           imem_rdata,
   output logic                      if_id_valid,
   output logic [XLEN-1:0]           if_id_instr,
   output logic [AW-1:0]             if_id_npc,
   input  logic                      id_ready,
   output logic [$clog2(DEPTH):0]    fifo_count
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]               perf_fetch,
   output logic [31:0]               perf_flush,
   output logic [31:0]               perf_stall
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUTST) + 1;
   localparam int EW = XLEN + AW;

   logic [AW-1:0] pc;
   logic [OW-1:0] outst;
   logic [OW-1:0] drop;
   logic [CW:0]   occ;
   logic          fire;
   logic          kill;
   logic          keep;
   logic          pop;
   logic [EW-1:0] e_din;
   logic [EW-1:0] e_dout;
   logic [AW-1:0] tag;
   logic [CW-1:0] tcount;

   // Credit: queued entries plus in-flight requests never exceed DEPTH.
   assign occ = {1'b0, fifo_count} + (CW+1)'(outst);

   assign imem_req = rst_n & ~ex_mem_pcsrc
                   & (outst < OW'(MAX_OUTST))
                   & (occ < (CW+1)'(DEPTH));
   assign imem_addr = pc;
   assign fire      = imem_req & imem_gnt;

   // Responses are stale while drop>0 or when a redirect lands now.
   assign kill = imem_rvalid & (ex_mem_pcsrc | (drop != '0));
   assign keep = imem_rvalid & ~kill;

   assign if_id_valid = (fifo_count != '0) & ~ex_mem_pcsrc;
   assign pop         = if_id_valid & id_ready;

   assign e_din = {imem_rdata, tag + AW'(PC_INC)};
   assign {if_id_instr, if_id_npc} = e_dout;

   ifetch_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_entry_q (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (ex_mem_pcsrc),
      .push  (keep),
      .din   (e_din),
      .pop   (pop),
      .dout  (e_dout),
      .count (fifo_count)
   );

   // Tags follow every request, including ones later discarded.
   ifetch_fifo #(
      .W     (AW),
      .DEPTH (DEPTH)
   ) u_tag_q (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (1'b0),
      .push  (fire),
      .din   (pc),
      .pop   (imem_rvalid),
      .dout  (tag),
      .count (tcount)
   );

   // PC: redirect wins, else advance on each accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc <= RESET_PC;
      else if (ex_mem_pcsrc)
         pc <= ex_mem_npc;
      else if (fire)
         pc <= pc + AW'(PC_INC);
   end

   // Outstanding request count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         outst <= '0;
      else
         case ({fire, imem_rvalid})
            2'b10:   outst <= outst + 1'b1;
            2'b01:   outst <= outst - 1'b1;
            default: outst <= outst;
         endcase
   end

   // Drop count: everything in flight at a redirect is stale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop <= '0;
      else if (ex_mem_pcsrc)
         drop <= outst - OW'(imem_rvalid);
      else if (kill)
         drop <= drop - 1'b1;
   end

   // A response needs a matching outstanding request and tag.
   a_rsp_has_req: assert property (
      @(posedge clk) disable iff (!rst_n)
      imem_rvalid |-> ((outst != '0) && (tcount != '0))
   );

`ifdef IFETCH_PERF_EN
   logic [31:0] flush_inc;

   assign flush_inc = (ex_mem_pcsrc ? 32'(fifo_count) : 32'd0)
                    + 32'(kill);

   // Free-running wrap-around performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch <= '0;
         perf_flush <= '0;
         perf_stall <= '0;
      end else begin
         perf_fetch <= perf_fetch + 32'(pop);
         perf_flush <= perf_flush + flush_inc;
         perf_stall <= perf_stall
                     + 32'(~if_id_valid & ~ex_mem_pcsrc);
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with an in-order memory model.
// Build with IFETCH_PERF_EN to also check the perf counters.
module tb_ifetch_prefetch;

   logic        clk;
   logic        rst_n;
   logic        ex_mem_pcsrc;
   logic [31:0] ex_mem_npc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_npc;
   logic        id_ready;
   logic [2:0]  fifo_count;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetch;
   logic [31:0] perf_flush;
   logic [31:0] perf_stall;
   logic [31:0] pf0;
`endif

   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   int          n_pops = 0;
   logic [31:0] exp_addr;
   logic [31:0] exp_npc;
   logic        resp_en;
   logic        fire_s = 1'b0;
   logic [31:0] addr_s = '0;
   logic [31:0] rq [$];

   ifetch_prefetch dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_mem_pcsrc (ex_mem_pcsrc),
      .ex_mem_npc   (ex_mem_npc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .if_id_valid  (if_id_valid),
      .if_id_instr  (if_id_instr),
      .if_id_npc    (if_id_npc),
      .id_ready     (id_ready),
      .fifo_count   (fifo_count)
`ifdef IFETCH_PERF_EN
      ,
      .perf_fetch   (perf_fetch),
      .perf_flush   (perf_flush),
      .perf_stall   (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   // Memory: sample accepted requests mid-cycle, answer in order.
   always @(negedge clk) begin
      fire_s = imem_req & imem_gnt;
      addr_s = imem_addr;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq.delete();
         imem_rvalid <= 1'b0;
         imem_rdata  <= '0;
      end else begin
         if (resp_en && rq.size() > 0) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= mem(rq.pop_front());
         end else begin
            imem_rvalid <= 1'b0;
         end
         if (fire_s)
            rq.push_back(addr_s);
      end
   end

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stream checks for the current cycle (called at negedge).
   task automatic sample();
      if (if_id_valid && id_ready) begin
         chk("pop_npc", 64'(if_id_npc), 64'(exp_npc));
         chk("pop_instr", 64'(if_id_instr),
             64'(mem(exp_npc - 32'd1)));
         exp_npc = exp_npc + 32'd1;
         n_pops++;
      end
      if (imem_req && imem_gnt) begin
         chk("req_addr", 64'(imem_addr), 64'(exp_addr));
         exp_addr = exp_addr + 32'd1;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sample();
         tick();
      end
   endtask

   // From full/idle: two pops and two unanswered requests.
   task automatic craft();
      resp_en  = 1'b0;
      id_ready = 1'b1;
      run(2);
      id_ready = 1'b0;
      run(1);
   endtask

   initial begin
      rst_n        = 1'b0;
      ex_mem_pcsrc = 1'b0;
      ex_mem_npc   = '0;
      imem_gnt     = 1'b0;
      id_ready     = 1'b0;
      resp_en      = 1'b1;
      exp_addr     = 32'd0;
      exp_npc      = 32'd1;

      // Reset state
      @(negedge clk);
      chk("rst_req", 64'(imem_req), 64'd0);
      chk("rst_valid", 64'(if_id_valid), 64'd0);
      chk("rst_instr", 64'(if_id_instr), 64'd0);
      chk("rst_npc", 64'(if_id_npc), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
      tick();

      // 1: streaming fetch
      rst_n    = 1'b1;
      imem_gnt = 1'b1;
      id_ready = 1'b1;
      @(negedge clk);
      chk("t1_c0_req", 64'(imem_req), 64'd1);
      chk("t1_c0_addr", 64'(imem_addr), 64'd0);
      chk("t1_c0_valid", 64'(if_id_valid), 64'd0);
      sample();
      tick();
      @(negedge clk);
      chk("t1_c1_addr", 64'(imem_addr), 64'd1);
      sample();
      tick();
      @(negedge clk);
      chk("t1_c2_req", 64'(imem_req), 64'd0);
      chk("t1_c2_count", 64'(fifo_count), 64'd0);
      sample();
      tick();
      @(negedge clk);
      chk("t1_c3_valid", 64'(if_id_valid), 64'd1);
      chk("t1_c3_npc", 64'(if_id_npc), 64'd1);
      chk("t1_c3_instr", 64'(if_id_instr), 64'(mem(32'd0)));
      chk("t1_c3_count", 64'(fifo_count), 64'd1);
      sample();
      tick();
      run(20);
      chk("t1_progress", 64'(exp_npc >= 32'd8), 64'd1);

      // 2: ID stall fills the queue, release drains in order
      id_ready = 1'b0;
      run(10);
      @(negedge clk);
      chk("t2_count", 64'(fifo_count), 64'd4);
      chk("t2_req", 64'(imem_req), 64'd0);
      chk("t2_valid", 64'(if_id_valid), 64'd1);
      chk("t2_head", 64'(if_id_npc), 64'(exp_npc));
      sample();
      tick();
      id_ready = 1'b1;
      run(15);

      // 3: redirect with 2 queued and 2 in flight
      id_ready = 1'b0;
      run(10);
      @(negedge clk);
      chk("t3_full", 64'(fifo_count), 64'd4);
      sample();
      tick();
      craft();
      ex_mem_pcsrc = 1'b1;
      ex_mem_npc   = 32'h40;
      @(negedge clk);
      chk("t3_kill_valid", 64'(if_id_valid), 64'd0);
      chk("t3_req", 64'(imem_req), 64'd0);
      chk("t3_count", 64'(fifo_count), 64'd2);
`ifdef IFETCH_PERF_EN
      pf0 = perf_flush;
`endif
      sample();
      tick();
      ex_mem_pcsrc = 1'b0;
      resp_en      = 1'b1;
      id_ready     = 1'b1;
      exp_addr     = 32'h40;
      exp_npc      = 32'h41;
      @(negedge clk);
      chk("t3_flushed", 64'(fifo_count), 64'd0);
      sample();
      tick();
      run(20);
      chk("t3_progress", 64'(exp_npc >= 32'h45), 64'd1);
`ifdef IFETCH_PERF_EN
      chk("t3_perf_flush", 64'(perf_flush - pf0), 64'd4);
`endif

      // 4: back-to-back redirects, last target wins
      ex_mem_pcsrc = 1'b1;
      ex_mem_npc   = 32'h10;
      @(negedge clk);
      chk("t4_req_a", 64'(imem_req), 64'd0);
      sample();
      tick();
      ex_mem_npc = 32'h20;
      @(negedge clk);
      chk("t4_req_b", 64'(imem_req), 64'd0);
      chk("t4_valid_b", 64'(if_id_valid), 64'd0);
      sample();
      tick();
      ex_mem_pcsrc = 1'b0;
      exp_addr     = 32'h20;
      exp_npc      = 32'h21;
      run(20);
      chk("t4_progress", 64'(exp_npc >= 32'h24), 64'd1);

      // 5: PC wrap at the top of the address space
      id_ready     = 1'b0;
      ex_mem_pcsrc = 1'b1;
      ex_mem_npc   = 32'hFFFF_FFFF;
      @(negedge clk);
      sample();
      tick();
      ex_mem_pcsrc = 1'b0;
      exp_addr     = 32'hFFFF_FFFF;
      exp_npc      = 32'h0;
      run(12);
      @(negedge clk);
      chk("t5_count", 64'(fifo_count), 64'd4);
      chk("t5_npc", 64'(if_id_npc), 64'd0);
      chk("t5_instr", 64'(if_id_instr),
          64'(mem(32'hFFFF_FFFF)));
      sample();
      tick();
      id_ready = 1'b1;
      run(10);
      chk("t5_progress", 64'(exp_npc >= 32'd4), 64'd1);

      // 6: reset mid-operation
      id_ready = 1'b0;
      run(10);
      craft();
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_req", 64'(imem_req), 64'd0);
      chk("t6_addr", 64'(imem_addr), 64'd0);
      chk("t6_valid", 64'(if_id_valid), 64'd0);
      chk("t6_instr", 64'(if_id_instr), 64'd0);
      chk("t6_npc", 64'(if_id_npc), 64'd0);
      chk("t6_count", 64'(fifo_count), 64'd0);
      tick();
      tick();
      rst_n    = 1'b1;
      resp_en  = 1'b1;
      id_ready = 1'b1;
      exp_addr = 32'd0;
      exp_npc  = 32'd1;
      n_pops   = 0;
      @(negedge clk);
      chk("t6_rel_req", 64'(imem_req), 64'd1);
      chk("t6_rel_addr", 64'(imem_addr), 64'd0);
      sample();
      tick();
      run(20);
      chk("t6_progress", 64'(exp_npc >= 32'd8), 64'd1);
`ifdef IFETCH_PERF_EN
      @(negedge clk);
      chk("t6_perf_fetch", 64'(perf_fetch), 64'(n_pops));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
